// File: rtl/rect_draw_scheduler_pkg.sv
// rect_draw_scheduler_pkg: shared FSM state encoding, default widths and a
// pointer-width helper for the rectangle draw scheduler.
// The optional watchdog is enabled with the RECT_SCHED_TIMEOUT_EN macro.
package rect_draw_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam int DEF_N_REQ = 3;
  localparam int DEF_X_W   = 10;
  localparam int DEF_Y_W   = 9;
  localparam int DEF_COL_W = 3;
`ifdef RECT_SCHED_TIMEOUT_EN
  localparam int DEF_TIMEOUT_CYCLES = 131072;
`endif

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// rect_draw_scheduler_rr_arbiter: combinational round-robin pick.
// The search starts at ptr and wraps from N_REQ-1 back to 0; the first
// pending requester wins and is reported one-hot and as an index.
module rect_draw_scheduler_rr_arbiter
  import rect_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PW   = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             grant_any
);

  // Walk the requesters in priority order starting at ptr.
  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: shares one rectangle drawer between N_REQ painters.
// A round-robin winner is accepted in IDLE, its rectangle and colour are
// latched and driven to the drawer until rd_done, then the owner gets a
// one-cycle req_done pulse.
// Optional watchdog: define RECT_SCHED_TIMEOUT_EN to abort draws that run
// TIMEOUT_CYCLES without rd_done and raise the sticky timeout_err flag.
//
// state | meaning
// IDLE  | waiting for a request; req_ready shows the round-robin winner
// DRAW  | rd_en high, latched rectangle driven until rd_done (or watchdog)
// DONE  | one-cycle req_done to the owner, round-robin pointer advances
module rect_draw_scheduler
  import rect_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int COL_W = DEF_COL_W
`ifdef RECT_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*X_W-1:0]   req_x,
  input  logic [N_REQ*Y_W-1:0]   req_y,
  input  logic [N_REQ*X_W-1:0]   req_w,
  input  logic [N_REQ*X_W-1:0]   req_h,
  input  logic [N_REQ*COL_W-1:0] req_colour,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       req_done,
  output logic                   rd_en,
  output logic [X_W-1:0]         rd_x,
  output logic [Y_W-1:0]         rd_y,
  output logic [X_W-1:0]         rd_w,
  output logic [X_W-1:0]         rd_h,
  input  logic                   rd_done,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   busy
`ifdef RECT_SCHED_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int PW = ptr_w(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  sched_state_t     state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [X_W-1:0]   sel_w;
  logic [X_W-1:0]   sel_h;
  logic [COL_W-1:0] sel_col;

`ifdef RECT_SCHED_TIMEOUT_EN
  localparam int TW = ptr_w(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;
`endif

  rect_draw_scheduler_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Winner's fields, picked straight from the packed request buses.
  assign sel_x   = req_x[grant_idx*X_W +: X_W];
  assign sel_y   = req_y[grant_idx*Y_W +: Y_W];
  assign sel_w   = req_w[grant_idx*X_W +: X_W];
  assign sel_h   = req_h[grant_idx*X_W +: X_W];
  assign sel_col = req_colour[grant_idx*COL_W +: COL_W];

  // Accept is only offered while idle; the handshake completes on the edge.
  assign req_ready = (state == ST_IDLE) ? grant : '0;

  // Scheduler FSM with latched drawer fields and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      req_done   <= '0;
      rd_en      <= 1'b0;
      rd_x       <= '0;
      rd_y       <= '0;
      rd_w       <= '0;
      rd_h       <= '0;
      vga_colour <= '0;
      busy       <= 1'b0;
`ifdef RECT_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner      <= grant_idx;
            rd_x       <= sel_x;
            rd_y       <= sel_y;
            rd_w       <= sel_w;
            rd_h       <= sel_h;
            vga_colour <= sel_col;
            busy       <= 1'b1;
            // An empty rectangle has nothing to plot, so skip the drawer.
            if (sel_w == '0 || sel_h == '0) begin
              state    <= ST_DONE;
              req_done <= grant;
            end else begin
              state <= ST_DRAW;
              rd_en <= 1'b1;
`ifdef RECT_SCHED_TIMEOUT_EN
              tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
            end
          end
        end
        ST_DRAW: begin
`ifdef RECT_SCHED_TIMEOUT_EN
          tmo_cnt <= tmo_cnt - 1'b1;
          if (rd_done || tmo_cnt == '0) begin
            if (!rd_done) timeout_err <= 1'b1;
`else
          if (rd_done) begin
`endif
            state    <= ST_DONE;
            rd_en    <= 1'b0;
            req_done <= ONE_HOT0 << owner;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
        end
        default: begin
          state <= ST_IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
